// File: rtl/pwm_ctrl_pkg.sv
// pwm_ctrl_pkg
// Shared types and helpers for the PWM setpoint sequencer.
//   seq_state_t  : sequencer FSM states.
//   seq_val_t    : widened arithmetic type (one bit wider than the widest
//                  supported setpoint) so steps never wrap.
//   step_toward  : next setpoint moving from cur toward goal by at most step.
package pwm_ctrl_pkg;

   typedef enum logic [2:0] {
      IDLE       = 3'd0,
      RAMP       = 3'd1,
      SWEEP_UP   = 3'd2,
      SWEEP_HOLD = 3'd3,
      SWEEP_DOWN = 3'd4
   } seq_state_t;

   // Widest setpoint the helper supports; callers zero-extend into seq_val_t.
   localparam int SEQ_MAX_W = 16;

   typedef logic [SEQ_MAX_W:0] seq_val_t;

   // The result always lies between cur and goal, so it can neither
   // overshoot the goal nor leave the [0, max] range the goal lives in.
   function automatic seq_val_t step_toward(input seq_val_t cur,
                                            input seq_val_t goal,
                                            input seq_val_t step);
      seq_val_t diff;
      seq_val_t nxt;
      if (goal > cur) begin
         diff = goal - cur;
         nxt  = (diff > step) ? (cur + step) : goal;
      end else begin
         diff = cur - goal;
         nxt  = (diff > step) ? (cur - step) : goal;
      end
      return nxt;
   endfunction

endpackage

// File: rtl/pwm_setpoint_sequencer_edge_detect.sv
// edge_detect
// Two-flop synchronizer followed by a rising-edge detector. Produces a
// single-clk pulse for every rising edge of din, however long din stays high.
//   clk   : system clock
//   nrst  : asynchronous active-low reset
//   din   : asynchronous level input
//   pulse : one-clk pulse, high the cycle after the synchronized rising edge
module edge_detect (
   input  logic clk,
   input  logic nrst,
   input  logic din,
   output logic pulse
);

   logic sync1;
   logic sync2;
   logic prev;

   // Synchronizer chain plus delayed copy for edge detection.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         sync1 <= 1'b0;
         sync2 <= 1'b0;
         prev  <= 1'b0;
      end else begin
         sync1 <= din;
         sync2 <= sync1;
         prev  <= sync2;
      end
   end

   assign pulse = sync2 & ~prev;

endmodule

// File: rtl/pwm_setpoint_sequencer.sv
// pwm_setpoint_sequencer
// Rate-limited setpoint controller for one PWM channel driving a needle.
// Slews mod_setpoint toward the accepted target by at most STEP codes per
// PWM period and runs a full-scale sweep test on request.
//   clk, nrst      : clock, asynchronous active-low reset
//   target         : requested needle position (valid/ready handshake)
//   target_valid   : target is valid
//   target_ready   : target can be accepted (IDLE/RAMP only)
//   sweep_req      : one-cycle request to start a sweep test
//   period_strobe  : period start strobe from the modulator (asynchronous)
//   mod_setpoint   : registered setpoint to the modulator
//   at_target      : high in IDLE
//   sweep_active   : high in any sweep state
module pwm_setpoint_sequencer
   import pwm_ctrl_pkg::*;
#(
   parameter int MOD_WIDTH    = 8,
   parameter int STEP         = 1,
   parameter int HOLD_PERIODS = 64
) (
   input  logic                 clk,
   input  logic                 nrst,
   input  logic [MOD_WIDTH-1:0] target,
   input  logic                 target_valid,
   output logic                 target_ready,
   input  logic                 sweep_req,
   input  logic                 period_strobe,
   output logic [MOD_WIDTH-1:0] mod_setpoint,
   output logic                 at_target,
   output logic                 sweep_active
);

   localparam int HOLD_W = (HOLD_PERIODS > 1) ? $clog2(HOLD_PERIODS) : 1;
   localparam logic [HOLD_W-1:0]    HOLD_LOAD = HOLD_W'(HOLD_PERIODS - 1);
   localparam logic [MOD_WIDTH-1:0] SP_MAX    = {MOD_WIDTH{1'b1}};
   localparam seq_val_t             STEP_EXT  = seq_val_t'(STEP);

   if (STEP < 1 || STEP > (2 ** MOD_WIDTH) - 1) begin : g_bad_step
      $error("STEP must be in 1..2**MOD_WIDTH-1");
   end
   if (HOLD_PERIODS < 1) begin : g_bad_hold
      $error("HOLD_PERIODS must be at least 1");
   end
   if (MOD_WIDTH < 1 || MOD_WIDTH > SEQ_MAX_W) begin : g_bad_width
      $error("MOD_WIDTH out of supported range");
   end

   seq_state_t           state;
   seq_state_t           state_nxt;
   logic [MOD_WIDTH-1:0] target_q;
   logic [MOD_WIDTH-1:0] target_q_nxt;
   logic [MOD_WIDTH-1:0] setpoint_nxt;
   logic [HOLD_W-1:0]    hold_cnt;
   logic [HOLD_W-1:0]    hold_cnt_nxt;
   logic [MOD_WIDTH-1:0] goal_s;
   logic [MOD_WIDTH-1:0] sp_step_s;
   logic                 tick_s;
   logic                 accept_s;

   edge_detect u_tick (
      .clk   (clk),
      .nrst  (nrst),
      .din   (period_strobe),
      .pulse (tick_s)
   );

   assign accept_s = target_valid & target_ready;

   // Goal the setpoint is slewing toward in the current state.
   always_comb begin
      goal_s = mod_setpoint;
      case (state)
         RAMP:       goal_s = target_q;
         SWEEP_UP:   goal_s = SP_MAX;
         SWEEP_DOWN: goal_s = '0;
         default:    goal_s = mod_setpoint;
      endcase
   end

   assign sp_step_s = MOD_WIDTH'(step_toward(seq_val_t'(mod_setpoint),
                                             seq_val_t'(goal_s), STEP_EXT));

   // Next-state, next-setpoint and hold counter logic.
   always_comb begin
      state_nxt    = state;
      hold_cnt_nxt = hold_cnt;
      if (tick_s) begin
         setpoint_nxt = sp_step_s;
      end else begin
         setpoint_nxt = mod_setpoint;
      end
      // A tick in the same cycle as an accept still steps toward the old
      // target; the new target_q only steers the following ticks.
      if (accept_s) begin
         target_q_nxt = target;
      end else begin
         target_q_nxt = target_q;
      end
      case (state)
         IDLE: begin
            if (sweep_req) begin
               state_nxt = SWEEP_UP;
            end else if (accept_s && (target != mod_setpoint)) begin
               state_nxt = RAMP;
            end else begin
               state_nxt = IDLE;
            end
         end
         RAMP: begin
            if (sweep_req) begin
               state_nxt = SWEEP_UP;
            end else if (tick_s && (sp_step_s == target_q) &&
                         !(accept_s && (target != sp_step_s))) begin
               state_nxt = IDLE;
            end else begin
               state_nxt = RAMP;
            end
         end
         SWEEP_UP: begin
            if (tick_s && (sp_step_s == SP_MAX)) begin
               state_nxt    = SWEEP_HOLD;
               hold_cnt_nxt = HOLD_LOAD;
            end else begin
               state_nxt = SWEEP_UP;
            end
         end
         SWEEP_HOLD: begin
            if (!tick_s) begin
               state_nxt = SWEEP_HOLD;
            end else if (hold_cnt == '0) begin
               state_nxt = SWEEP_DOWN;
            end else begin
               hold_cnt_nxt = hold_cnt - HOLD_W'(1);
            end
         end
         SWEEP_DOWN: begin
            if (tick_s && (sp_step_s == '0)) begin
               state_nxt = (target_q == '0) ? IDLE : RAMP;
            end else begin
               state_nxt = SWEEP_DOWN;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // State, datapath registers and outputs decoded from the next state.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state        <= IDLE;
         target_q     <= '0;
         hold_cnt     <= '0;
         mod_setpoint <= '0;
         target_ready <= 1'b1;
         at_target    <= 1'b1;
         sweep_active <= 1'b0;
      end else begin
         state        <= state_nxt;
         target_q     <= target_q_nxt;
         hold_cnt     <= hold_cnt_nxt;
         mod_setpoint <= setpoint_nxt;
         target_ready <= (state_nxt == IDLE) || (state_nxt == RAMP);
         at_target    <= (state_nxt == IDLE);
         sweep_active <= (state_nxt != IDLE) && (state_nxt != RAMP);
      end
   end

endmodule

// File: tb/tb_pwm_setpoint_sequencer.sv
module tb_pwm_setpoint_sequencer;

   localparam int MW       = 8;
   localparam int STEP     = 4;
   localparam int HOLD     = 3;
   localparam int PERIOD   = 50;
   localparam int WIDTH    = 10;
   localparam int FULL     = 255;
   localparam int PH_NORM  = 0;
   localparam int PH_UP    = 1;
   localparam int PH_HOLD  = 2;
   localparam int PH_DOWN  = 3;

   logic          clk = 1'b0;
   logic          nrst = 1'b0;
   logic [MW-1:0] target = '0;
   logic          target_valid = 1'b0;
   logic          sweep_req = 1'b0;
   logic          period_strobe = 1'b0;
   logic [MW-1:0] mod_setpoint;
   logic          target_ready;
   logic          at_target;
   logic          sweep_active;

   int n_cmp = 0;
   int n_fail = 0;

   // reference model state: needle position, remembered target, sweep phase
   int m_sp, m_tq, m_phase, m_hold_left;
   bit m_idle;

   pwm_setpoint_sequencer #(.MOD_WIDTH(MW), .STEP(STEP), .HOLD_PERIODS(HOLD)) dut (
      .clk(clk), .nrst(nrst), .target(target), .target_valid(target_valid),
      .target_ready(target_ready), .sweep_req(sweep_req),
      .period_strobe(period_strobe), .mod_setpoint(mod_setpoint),
      .at_target(at_target), .sweep_active(sweep_active)
   );

   always #5 clk = ~clk;

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic int m_move(int cur, int goal);
      int d;
      d = goal - cur;
      if (d > STEP) d = STEP;
      if (d < -STEP) d = -STEP;
      return cur + d;
   endfunction

   function automatic logic [MW+2:0] m_out();
      logic e_at, e_rdy, e_sw;
      e_rdy = (m_phase == PH_NORM);
      e_at  = e_rdy && m_idle;
      e_sw  = !e_rdy;
      return {MW'(m_sp), e_at, e_rdy, e_sw};
   endfunction

   task automatic model_reset();
      m_sp = 0; m_tq = 0; m_phase = PH_NORM; m_idle = 1'b1; m_hold_left = 0;
   endtask

   task automatic model_tick();
      case (m_phase)
         PH_NORM: if (!m_idle) begin
            m_sp = m_move(m_sp, m_tq);
            m_idle = (m_sp == m_tq);
         end
         PH_UP: begin
            m_sp = m_move(m_sp, FULL);
            if (m_sp == FULL) begin m_phase = PH_HOLD; m_hold_left = HOLD; end
         end
         PH_HOLD: begin
            m_hold_left--;
            if (m_hold_left == 0) m_phase = PH_DOWN;
         end
         PH_DOWN: begin
            m_sp = m_move(m_sp, 0);
            if (m_sp == 0) begin m_phase = PH_NORM; m_idle = (m_tq == 0); end
         end
         default: ;
      endcase
   endtask

   task automatic model_inputs(bit v, int t, bit s);
      if (m_phase == PH_NORM) begin
         if (v) begin
            m_tq = t;
            if (m_idle && t != m_sp) m_idle = 1'b0;
         end
         if (s) begin m_phase = PH_UP; m_idle = 1'b0; end
      end
   endtask

   // One-cycle drive of handshake/sweep inputs, model updated at the edge.
   task automatic drive_inputs(bit v, int t, bit s);
      @(posedge clk); #1;
      target = MW'(t); target_valid = v; sweep_req = s;
      @(posedge clk); #1;
      model_inputs(v, t, s);
      target_valid = 1'b0; sweep_req = 1'b0;
   endtask

   // One full PWM period with a WIDTH-clk strobe; model ticks at update time.
   task automatic do_tick();
      @(posedge clk); #1 period_strobe = 1'b1;
      repeat (3) @(posedge clk);
      #1 model_tick();
      repeat (WIDTH - 3) @(posedge clk);
      #1 period_strobe = 1'b0;
      repeat (PERIOD - WIDTH - 1) @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      nrst = 1'b0;
      model_reset();
      repeat (3) @(posedge clk);
      #1 nrst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      n_cmp++;
      if ({mod_setpoint, at_target, target_ready, sweep_active} !== {8'd0, 1'b1, 1'b1, 1'b0}) begin
         n_fail++;
         $display("FAIL reset: got sp=%0d at=%b rdy=%b sw=%b, want sp=0 at=1 rdy=1 sw=0",
                  mod_setpoint, at_target, target_ready, sweep_active);
      end
   endtask

   task automatic test_ramp_up();
      int exp_sp[3] = '{4, 8, 10};
      drive_inputs(1'b1, 10, 1'b0);
      n_cmp++;
      if (at_target !== 1'b0) begin
         n_fail++; $display("FAIL ramp_accept_at_target: got %b want 0", at_target);
      end
      for (int i = 0; i < 5; i++) begin
         do_tick();
         n_cmp++;
         if (mod_setpoint !== MW'((i < 3) ? exp_sp[i] : 10) ||
             {mod_setpoint, at_target, target_ready, sweep_active} !== m_out()) begin
            n_fail++;
            $display("FAIL ramp_up_tick%0d: got sp=%0d at=%b, want sp=%0d at=%b",
                     i + 1, mod_setpoint, at_target, m_sp, (i >= 2));
         end
      end
   endtask

   task automatic test_retarget();
      int exp_sp[3] = '{4, 2, 2};
      drive_inputs(1'b1, 200, 1'b0);
      do_tick(); do_tick();
      n_cmp++;
      if (mod_setpoint !== 8'd18) begin
         n_fail++; $display("FAIL retarget_pre: got sp=%0d want 18", mod_setpoint);
      end
      // bring needle to 8 first: retarget to 8, then climb from it
      drive_inputs(1'b1, 8, 1'b0);
      for (int i = 0; i < 10 && !m_idle; i++) do_tick();
      drive_inputs(1'b1, 200, 1'b0);
      drive_inputs(1'b1, 2, 1'b0);
      for (int i = 0; i < 3; i++) begin
         do_tick();
         n_cmp++;
         if (mod_setpoint !== MW'(exp_sp[i]) ||
             {mod_setpoint, at_target, target_ready, sweep_active} !== m_out()) begin
            n_fail++;
            $display("FAIL retarget_tick%0d: got sp=%0d at=%b, want sp=%0d at=%b",
                     i + 1, mod_setpoint, at_target, exp_sp[i], m_idle);
         end
      end
   endtask

   task automatic test_sweep();
      int  ticks;
      int  at_max;
      bit  bad;
      drive_inputs(1'b1, 10, 1'b0);
      for (int i = 0; i < 10 && !m_idle; i++) do_tick();
      drive_inputs(1'b0, 0, 1'b1);
      n_cmp++;
      if ({target_ready, sweep_active, at_target} !== 3'b010) begin
         n_fail++;
         $display("FAIL sweep_start: got rdy=%b sw=%b at=%b want 0 1 0",
                  target_ready, sweep_active, at_target);
      end
      ticks = 0; at_max = 0; bad = 1'b0;
      while (!(m_phase == PH_NORM && m_idle) && ticks < 250) begin
         if (ticks == 5) drive_inputs(1'b1, 50, 1'b0);
         if (ticks == 20) drive_inputs(1'b0, 0, 1'b1);
         do_tick();
         ticks++;
         if (mod_setpoint == 8'd255) at_max++;
         n_cmp++;
         if ({mod_setpoint, at_target, target_ready, sweep_active} !== m_out()) begin
            n_fail++; bad = 1'b1;
            $display("FAIL sweep_tick%0d: got sp=%0d at=%b rdy=%b sw=%b, want sp=%0d phase=%0d",
                     ticks, mod_setpoint, at_target, target_ready, sweep_active, m_sp, m_phase);
         end
         if (bad) break;
      end
      n_cmp++;
      if (ticks >= 250 || at_max != 4 || mod_setpoint !== 8'd10) begin
         n_fail++;
         $display("FAIL sweep_summary: got ticks=%0d full_scale_ticks=%0d sp=%0d, want <250 4 10",
                  ticks, at_max, mod_setpoint);
      end
   endtask

   task automatic test_wide_strobe();
      int changes;
      drive_inputs(1'b1, 100, 1'b0);
      @(posedge clk); #1 period_strobe = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      n_cmp++;
      if (mod_setpoint !== 8'd10) begin
         n_fail++; $display("FAIL wide_pre_update: got sp=%0d want 10", mod_setpoint);
      end
      @(posedge clk); #1 model_tick();
      n_cmp++;
      if (mod_setpoint !== 8'd14 || mod_setpoint !== MW'(m_sp)) begin
         n_fail++; $display("FAIL wide_update: got sp=%0d want 14", mod_setpoint);
      end
      changes = 0;
      for (int i = 0; i < 997; i++) begin
         @(posedge clk); #1;
         if (mod_setpoint !== 8'd14) changes++;
      end
      period_strobe = 1'b0;
      repeat (PERIOD) @(posedge clk);
      #1;
      n_cmp++;
      if (changes != 0 || mod_setpoint !== 8'd14) begin
         n_fail++;
         $display("FAIL wide_single_step: got extra_changes=%0d sp=%0d want 0 14", changes, mod_setpoint);
      end
   endtask

   task automatic test_tick_with_accept();
      bit rdy;
      @(posedge clk); #1 period_strobe = 1'b1;
      repeat (2) @(posedge clk);
      #1 target = 8'd5; target_valid = 1'b1;
      rdy = (m_phase == PH_NORM);
      @(posedge clk); #1 target_valid = 1'b0;
      model_tick();
      model_inputs(rdy, 5, 1'b0);
      repeat (WIDTH - 3) @(posedge clk);
      #1 period_strobe = 1'b0;
      repeat (PERIOD - WIDTH - 1) @(posedge clk);
      #1;
      n_cmp++;
      if (mod_setpoint !== 8'd18 || {mod_setpoint, at_target, target_ready, sweep_active} !== m_out()) begin
         n_fail++; $display("FAIL coincide_old_target: got sp=%0d want 18", mod_setpoint);
      end
      do_tick();
      n_cmp++;
      if (mod_setpoint !== 8'd14) begin
         n_fail++; $display("FAIL coincide_new_target: got sp=%0d want 14", mod_setpoint);
      end
   endtask

   task automatic test_random();
      int r, n, t, sweeps;
      sweeps = 0;
      for (int it = 0; it < 30; it++) begin
         r = $urandom_range(0, 9);
         t = (($urandom_range(0, 3) == 0)) ? m_sp : $urandom_range(0, 255);
         if (r < 6) drive_inputs(1'b1, t, 1'b0);
         else if (r == 6 && sweeps < 2) begin
            drive_inputs($urandom_range(0, 1) == 1, t, 1'b1);
            sweeps++;
         end
         n = $urandom_range(1, 4);
         for (int k = 0; k < n; k++) begin
            do_tick();
            n_cmp++;
            if ({mod_setpoint, at_target, target_ready, sweep_active} !== m_out()) begin
               n_fail++;
               $display("FAIL random_it%0d_tick%0d: got sp=%0d at=%b rdy=%b sw=%b, want sp=%0d tq=%0d phase=%0d idle=%b",
                        it, k, mod_setpoint, at_target, target_ready, sweep_active,
                        m_sp, m_tq, m_phase, m_idle);
            end
         end
      end
   endtask

   task automatic test_reset_mid(bit in_sweep);
      for (int i = 0; i < 250 && m_phase != PH_NORM; i++) do_tick();
      if (in_sweep) drive_inputs(1'b0, 0, 1'b1);
      else drive_inputs(1'b1, ((m_sp > 128) ? 0 : 200), 1'b0);
      repeat (3) do_tick();
      @(posedge clk); #3 nrst = 1'b0;
      #1;
      model_reset();
      n_cmp++;
      if ({mod_setpoint, at_target, target_ready, sweep_active} !== {8'd0, 1'b1, 1'b1, 1'b0}) begin
         n_fail++;
         $display("FAIL reset_mid_%s: got sp=%0d at=%b rdy=%b sw=%b, want 0 1 1 0",
                  in_sweep ? "sweep" : "ramp", mod_setpoint, at_target, target_ready, sweep_active);
      end
      repeat (2) @(posedge clk);
      #1 nrst = 1'b1;
      do_tick();
      n_cmp++;
      if ({mod_setpoint, at_target, target_ready, sweep_active} !== {8'd0, 1'b1, 1'b1, 1'b0}) begin
         n_fail++;
         $display("FAIL reset_release_%s: got sp=%0d at=%b, want sp=0 at=1",
                  in_sweep ? "sweep" : "ramp", mod_setpoint, at_target);
      end
   endtask

   initial begin
      test_reset();
      test_ramp_up();
      test_retarget();
      test_sweep();
      test_wide_strobe();
      test_tick_with_accept();
      test_random();
      test_reset_mid(1'b0);
      test_reset_mid(1'b1);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/pwm_setpoint_sequencer.md
# pwm_setpoint_sequencer

Rate-limited setpoint controller for one `pwm_modulator` channel driving an ammeter needle. It accepts target deflections over a valid/ready handshake and slews `mod_setpoint` toward the target by at most `STEP` codes per PWM period, so the needle never jumps. It also runs a full-scale sweep test: 0 → max → hold → 0 → back to the last target. It sits between the timekeeping logic and `pwm_modulator`, and is paced by the modulator's `start_strobe`.

## Interface
- `MOD_WIDTH`, 8, setpoint bitness; must match `pwm_modulator`.
- `STEP`, 1, maximum setpoint change per PWM period; range 1..2**MOD_WIDTH-1; 0 is illegal (elaboration assertion).
- `HOLD_PERIODS`, 64, number of PWM periods the sweep holds at full scale; must be ≥1.
- `clk`  in  1  system clock; the only clock.
- `nrst`  in  1  asynchronous active-low reset.
- `target`  in  MOD_WIDTH  requested needle position.
- `target_valid`  in  1  `target` is valid.
- `target_ready`  out  1  block accepts `target`; transfer occurs on `target_valid & target_ready`.
- `sweep_req`  in  1  single-cycle request to start a sweep test.
- `period_strobe`  in  1  `start_strobe` from `pwm_modulator`; it lives in the divided-clock domain, so it is wide and asynchronous-ish.
- `mod_setpoint`  out  MOD_WIDTH  registered setpoint to `pwm_modulator`.
- `at_target`  out  1  high when the FSM is in IDLE.
- `sweep_active`  out  1  high in any SWEEP_* state.

## Operation
- **Tick:** `period_strobe` goes through a 2-flop synchronizer, then rising-edge detection. This yields a 1-clk `tick` per PWM period regardless of strobe width.
- **Registers:** `target_q` (last accepted target), `mod_setpoint`, `hold_cnt`.
- **Step rule:** on each `tick`, `mod_setpoint` moves toward the goal by min(`STEP`, |goal − setpoint|).
  - Use MOD_WIDTH+1-bit arithmetic.
  - Never overshoot, never wrap: saturate at 0 and at 2**MOD_WIDTH-1.
- **FSM states:** IDLE, RAMP, SWEEP_UP, SWEEP_HOLD, SWEEP_DOWN.
  - **IDLE:** setpoint == `target_q`. On accept of a new `target` different from the setpoint, go to RAMP. On `sweep_req`, go to SWEEP_UP.
  - **RAMP:** goal = `target_q`. New targets are accepted at any time and retarget immediately; direction may reverse. When the setpoint reaches `target_q` after a tick, go to IDLE. On `sweep_req`, go to SWEEP_UP.
  - **SWEEP_UP:** goal = max. On reaching max, go to SWEEP_HOLD and load `hold_cnt` = `HOLD_PERIODS`-1.
  - **SWEEP_HOLD:** `hold_cnt` decrements on each tick. A tick while `hold_cnt`==0 moves to SWEEP_DOWN.
  - **SWEEP_DOWN:** goal = 0. On reaching 0, go to RAMP (or IDLE if `target_q`==0).
- **Handshake:**
  - `target_ready` = 1 in IDLE and RAMP, 0 in SWEEP_*.
  - Holding `target_valid` high with a value equal to the setpoint in IDLE is accepted and stays in IDLE.
- **Simultaneous target accept and `sweep_req`:** `target_q` updates and the sweep starts; after the sweep the block ramps to the new target.
- `sweep_req` during SWEEP_* is ignored.
- **Tick coinciding with target accept:** that tick steps toward the previous `target_q`. The new target takes effect on the next tick.

## Timing
- **Reset values:** `mod_setpoint`=0, `target_q`=0, state IDLE, `target_ready`=1, `at_target`=1, `sweep_active`=0, `hold_cnt`=0, synchronizer flops 0.
- **Strobe latency:** `period_strobe` rising edge → `mod_setpoint` update is 3 clk (2 synchronizer + 1 edge-detect/update register).
- **Outputs:** all outputs are registered or decoded from state registers; no combinational path from inputs to outputs except none; `target_ready` is from state only.
- **Handshake latency:** accept → `at_target` deasserts on the next clk edge (if a move is needed).
- **Reset mid-operation:** all registers clear asynchronously. `mod_setpoint` returns to 0 instantly; no ramp-down.

## Structure
- **Package `pwm_ctrl_pkg`:**
  - `typedef enum logic [2:0]` `seq_state_t` {IDLE, RAMP, SWEEP_UP, SWEEP_HOLD, SWEEP_DOWN}.
  - A function `step_toward(cur, goal, step)` returning the saturated next value.
- **Sub-module `edge_detect`:** 2-flop synchronizer plus rising-edge pulse, clocked by `clk`, reset by `nrst`.
- **Top:** FSM, `target_q`, `hold_cnt`, setpoint register.

## Test plan
All scenarios use MOD_WIDTH=8, STEP=4, HOLD_PERIODS=3, with a strobe every 50 clk.
- **Reset:** release reset → `mod_setpoint`=0, `at_target`=1, `target_ready`=1, `sweep_active`=0.
- **Ramp up:** accept `target`=10 → setpoint 4, 8, 10 on ticks 1–3; `at_target` rises after tick 3; no further changes afterwards.
- **Retarget mid-ramp:** ramp toward 200; at setpoint 8, accept `target`=2 → 4, 2, then IDLE; no overshoot below 2.
- **Sweep:** from IDLE at 10, pulse `sweep_req` → climbs by 4 to 254, then 255; holds 3 ticks; descends to 0; returns to 10.
  - `target_ready`=0 and `sweep_active`=1 throughout.
  - `target_valid`=50 during the sweep is not accepted.
  - A second `sweep_req` is ignored.
- **Wide strobe:** hold `period_strobe` high for 1000 clk during a ramp → exactly one step of 4, occurring 3 clk after the rising edge.
- **Reset mid-ramp and mid-sweep:** assert `nrst` → `mod_setpoint`=0 and state IDLE immediately; after release, `target_q`=0.
